// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
//   Word-read port between the instruction-fetch stage and the memory
//   controller.
//   master (fetch stage):  drives mem_req/mem_addr, receives mem_done/mem_data
//   slave  (mem ctrl)   :  receives mem_req/mem_addr, drives mem_done/mem_data
//   mem_req   1         word-read request, held until mem_done
//   mem_addr  ADDR_LEN  read address, stable while mem_req=1
//   mem_done  1         one-cycle completion pulse
//   mem_data  INST_LEN  read data, valid in the mem_done cycle
// ---------------------------------------------------------------------------
interface if_fetch_if #(
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32
);
  logic                mem_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_done;
  logic [INST_LEN-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_done,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_done,
    output mem_data
  );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage with a direct-mapped, one-word-per-line
//   instruction cache. A miss issues a word read on the memory port and
//   holds stall_req until the line is filled; the instruction is then
//   emitted from the cache on the following cycle.
// Ports
//   clk, rst    clock, synchronous active-high reset
//   pc          fetch address (word aligned)
//   jump_flag   redirect from EX; squashes the IF outputs this edge
//   stall       ctrl stall vector; stall[1] freezes the IF outputs
//   stall_req   to ctrl; instruction at pc not yet available
//   mem         memory controller word port (master side)
//   if_pc       pc of the emitted instruction
//   if_inst     emitted instruction (bubble = addi x0,x0,0)
//   if_valid    if_inst is a real instruction
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter int ADDR_LEN    = 32,
  parameter int INST_LEN    = 32,
  parameter int CACHE_LINES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] pc,
  input  logic                jump_flag,
  input  logic [5:0]          stall,
  output logic                stall_req,
  if_fetch_if.master          mem,
  output logic [ADDR_LEN-1:0] if_pc,
  output logic [INST_LEN-1:0] if_inst,
  output logic                if_valid
);

  localparam int IDX   = $clog2(CACHE_LINES);
  localparam int TAG_W = ADDR_LEN - IDX - 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_DROP     = 2'd2;

  localparam logic [INST_LEN-1:0] BUBBLE = INST_LEN'(32'h0000_0013);

  logic [1:0]          state_r;
  logic                mem_req_r;
  logic [ADDR_LEN-1:0] mem_addr_r;
  logic [ADDR_LEN-1:0] if_pc_r;
  logic [INST_LEN-1:0] if_inst_r;
  logic                if_valid_r;

  logic [CACHE_LINES-1:0] valid_r;
  logic [TAG_W-1:0]       tag_ram_r  [CACHE_LINES];
  logic [INST_LEN-1:0]    data_ram_r [CACHE_LINES];

  logic [IDX-1:0]   idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit_s;
  logic             fill_s;
  logic [IDX-1:0]   fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic             stall_req_s;
  logic             unused_s;

  assign idx_s = pc[IDX+1:2];
  assign tag_s = pc[ADDR_LEN-1:IDX+2];
  assign hit_s = valid_r[idx_s] && (tag_ram_r[idx_s] == tag_s);

  // The fill uses the latched request address, not pc: in DROP pc already
  // points at the jump target while the old request is still outstanding.
  assign fill_s     = ((state_r == ST_WAIT_MEM) || (state_r == ST_DROP)) && mem.mem_done;
  assign fill_idx_s = mem_addr_r[IDX+1:2];
  assign fill_tag_s = mem_addr_r[ADDR_LEN-1:IDX+2];

  // Only stall[1] matters here; pc is word aligned.
  assign unused_s = ^{stall[5:2], stall[0], pc[1:0]};

  // stall_req: depends only on state and the lookup, never on stall.
  always_comb begin
    stall_req_s = 1'b0;
    if (state_r != ST_IDLE) begin
      stall_req_s = 1'b1;
    end else begin
      stall_req_s = !hit_s;
    end
  end

  assign stall_req    = stall_req_s;
  assign mem.mem_req  = mem_req_r;
  assign mem.mem_addr = mem_addr_r;
  assign if_pc        = if_pc_r;
  assign if_inst      = if_inst_r;
  assign if_valid     = if_valid_r;

  // Fetch FSM and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= {ADDR_LEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A jump cycle's pc is stale; the target is looked up next cycle.
          if (!jump_flag && !hit_s) begin
            state_r    <= ST_WAIT_MEM;
            mem_req_r  <= 1'b1;
            mem_addr_r <= pc;
          end else begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        ST_WAIT_MEM: begin
          if (mem.mem_done) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end else if (jump_flag) begin
            state_r <= ST_DROP;
          end else begin
            state_r <= ST_WAIT_MEM;
          end
        end
        ST_DROP: begin
          // The issued request runs to completion; it is never aborted.
          if (mem.mem_done) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Line valid bits: cleared by reset, set by a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {CACHE_LINES{1'b0}};
    end else if (fill_s) begin
      valid_r[fill_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data arrays; contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_s && !rst) begin
      tag_ram_r[fill_idx_s]  <= fill_tag_s;
      data_ram_r[fill_idx_s] <= mem.mem_data;
    end
  end

  // IF/ID outputs: jump squashes even under stall[1]; stall[1] holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_r    <= {ADDR_LEN{1'b0}};
      if_inst_r  <= BUBBLE;
      if_valid_r <= 1'b0;
    end else if (jump_flag) begin
      if_inst_r  <= BUBBLE;
      if_valid_r <= 1'b0;
    end else if (stall[1]) begin
      if_pc_r    <= if_pc_r;
      if_inst_r  <= if_inst_r;
      if_valid_r <= if_valid_r;
    end else if ((state_r == ST_IDLE) && hit_s) begin
      if_pc_r    <= pc;
      if_inst_r  <= data_ram_r[idx_s];
      if_valid_r <= 1'b1;
    end else begin
      if_inst_r  <= BUBBLE;
      if_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// pc / jump / stall / reset traffic, compared against a cache model that
// keys lines by full word address.
module tb_if_fetch;
  localparam int LINES = 64;
  localparam logic [31:0] BUB = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        jump_flag;
  logic [5:0]  stall;
  logic        stall_req;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  if_fetch_if #(.ADDR_LEN(32), .INST_LEN(32)) mem_bus ();

  if_fetch #(.ADDR_LEN(32), .INST_LEN(32), .CACHE_LINES(LINES)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .jump_flag (jump_flag),
    .stall     (stall),
    .stall_req (stall_req),
    .mem       (mem_bus),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_known = 0;
  int          m_phase;          // 0 idle, 1 waiting for memory, 2 dropping
  bit          m_valid [LINES];
  logic [31:0] m_line_addr [LINES];
  logic [31:0] m_line_data [LINES];
  logic        m_mem_req;
  logic [31:0] m_mem_addr;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic        m_if_valid;
  int          resp_left;
  int          next_delay = 2;
  logic        obs_sr;
  logic        last_sr = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_hit(input logic [31:0] p);
    int idx;
    idx = int'((p >> 2) % LINES);
    return m_valid[idx] && (m_line_addr[idx] == p);
  endfunction

  task automatic model_edge(input bit r, input logic [31:0] p, input bit j, input bit s1,
                            input bit d, input logic [31:0] dat);
    bit h;
    int idx;
    h = m_hit(p);
    if (r) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_phase = 0; m_mem_req = 1'b0; m_mem_addr = 32'h0;
      m_if_pc = 32'h0; m_if_inst = BUB; m_if_valid = 1'b0;
      m_known = 1;
      return;
    end
    if (j) begin
      m_if_inst = BUB; m_if_valid = 1'b0;
    end else if (!s1) begin
      if (m_phase == 0 && h) begin
        m_if_pc = p; m_if_inst = m_line_data[int'((p >> 2) % LINES)]; m_if_valid = 1'b1;
      end else begin
        m_if_inst = BUB; m_if_valid = 1'b0;
      end
    end
    if (m_phase == 0) begin
      if (!j && !h) begin
        m_phase = 1; m_mem_req = 1'b1; m_mem_addr = p; resp_left = next_delay;
      end
    end else if (d) begin
      idx = int'((m_mem_addr >> 2) % LINES);
      m_valid[idx] = 1; m_line_addr[idx] = m_mem_addr; m_line_data[idx] = dat;
      m_phase = 0; m_mem_req = 1'b0;
    end else if (j) begin
      m_phase = 2;
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cyc(input bit r, input logic [31:0] p, input bit j, input bit s1, input bit fd);
    bit d;
    logic [31:0] dat;
    logic [5:0] sv;
    logic exp_sr;
    if (fd) begin
      d = 1; dat = 32'hDEAD_BEEF;
    end else if (m_known && m_mem_req) begin
      if (resp_left == 0) begin d = 1; dat = mem_word(m_mem_addr); end
      else begin resp_left--; d = 0; dat = $urandom; end
    end else begin
      d = ($urandom_range(0, 19) == 0); dat = $urandom;
    end
    sv = 6'($urandom); sv[1] = s1;
    rst = r; pc = p; jump_flag = j; stall = sv;
    mem_bus.mem_done = d; mem_bus.mem_data = dat;
    #1;
    obs_sr = stall_req;
    exp_sr = (m_phase != 0) || !m_hit(p);
    if (m_known) check("stall_req", {31'h0, stall_req}, {31'h0, exp_sr});
    last_sr = exp_sr;
    @(posedge clk);
    model_edge(r, p, j, s1, d, dat);
    #1;
    check("if_valid", {31'h0, if_valid}, {31'h0, m_if_valid});
    check("if_inst", if_inst, m_if_inst);
    check("mem_req", {31'h0, mem_bus.mem_req}, {31'h0, m_mem_req});
    if (m_if_valid) check("if_pc", if_pc, m_if_pc);
    if (m_mem_req) check("mem_addr", mem_bus.mem_addr, m_mem_addr);
    @(negedge clk);
    mem_bus.mem_done = 1'b0;
  endtask

  task automatic run_until_hit(input logic [31:0] p, input int maxc);
    int n;
    n = 0;
    do begin
      cyc(0, p, 0, 0, 0);
      n++;
    end while (obs_sr && n < maxc);
    if (obs_sr) check("hit_timeout", {31'h0, obs_sr}, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'($urandom_range(0, 3)) * 32'd256 + 32'($urandom_range(0, 7)) * 32'd4
         + 32'($urandom_range(0, 1)) * 32'h0010_0000;
  endfunction

  initial begin
    int cnt;
    logic [31:0] cur_pc;
    bit r, j, s1;
    rst = 1'b1; pc = 32'h0; jump_flag = 1'b0; stall = 6'h0;
    mem_bus.mem_done = 1'b0; mem_bus.mem_data = 32'h0;
    @(negedge clk);

    // Reset state
    cyc(1, 32'h0, 0, 0, 0);
    cyc(1, 32'h0, 0, 0, 0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);

    // 1: cold miss at 0x0, memory answers 3 cycles after the request
    next_delay = 3; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 32'h0, 0, 0, 0);
      if (obs_sr) cnt++;
    end
    check("t1_stall_cycles", 32'(cnt), 32'd5);
    check("t1_if_inst", if_inst, 32'h0050_0093);
    check("t1_if_pc", if_pc, 32'h0);
    check("t1_if_valid", {31'h0, if_valid}, 32'h1);

    // 2/5: hit held under stall[1]; jump under stall[1] still squashes
    cyc(0, 32'h0, 0, 1, 0);
    check("t2_hit_no_stall", {31'h0, obs_sr}, 32'h0);
    cyc(0, 32'h0, 0, 1, 0);
    check("t5_frozen_valid", {31'h0, if_valid}, 32'h1);
    cyc(0, 32'h0, 1, 1, 0);
    check("t5_jump_squash", {31'h0, if_valid}, 32'h0);

    // 3: conflicting line 0x100 evicts 0x0
    next_delay = 1;
    run_until_hit(32'h100, 20);
    cyc(0, 32'h0, 0, 0, 0);
    check("t3_conflict_miss", {31'h0, obs_sr}, 32'h1);
    run_until_hit(32'h0, 20);

    // 4: jump while waiting for 0x8, target 0x40
    next_delay = 4;
    cyc(0, 32'h8, 0, 0, 0);
    cyc(0, 32'h8, 0, 0, 0);
    cyc(0, 32'h8, 1, 0, 0);
    run_until_hit(32'h40, 30);
    cyc(0, 32'h8, 0, 0, 0);
    check("t4_line2_filled", {31'h0, obs_sr}, 32'h0);

    // 6: reset mid-fetch, then a stale mem_done while idle
    next_delay = 5;
    cyc(0, 32'h20, 0, 0, 0);
    cyc(0, 32'h20, 0, 0, 0);
    cyc(1, 32'h20, 0, 0, 0);
    check("t6_rst_mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
    cyc(0, 32'h20, 0, 0, 1);
    next_delay = 2;
    run_until_hit(32'h20, 20);
    cyc(0, 32'h20, 0, 0, 0);
    check("t6_refetched", if_inst, mem_word(32'h20));

    // Random traffic
    cur_pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      j  = !r && ($urandom_range(0, 11) == 0);
      s1 = ($urandom_range(0, 4) == 0);
      if (j) cur_pc = rand_pc();
      else if (!last_sr && $urandom_range(0, 9) < 7) cur_pc = rand_pc();
      next_delay = $urandom_range(0, 5);
      cyc(r, cur_pc, j, s1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
